// File: rtl/finalcarrera_multi.sv
// Conditions N_CH mechanical inputs: two-flop sync, optional inversion, a tick-paced
// consecutive-sample filter, edge pulses, sticky latches and an any-active summary.
module finalcarrera_multi #(
  parameter int              N_CH        = 2,
  parameter int              FILTER_LEN  = 8,
  parameter logic [N_CH-1:0] INVERT      = {N_CH{1'b0}},
  parameter logic            RESET_LEVEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] latch_clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] latch,
  output logic            any_active
);

  localparam int             CNT_W    = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [N_CH-1:0]  sync1, sync2;
  logic [N_CH-1:0]  x;
  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  level_nxt, rise_nxt, fall_nxt, latch_nxt;

  assign x = sync2 ^ INVERT;

  // Any agreeing sample restarts the window; tick gaps only pause it.
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    for (int i = 0; i < N_CH; i++) begin
      if (x[i] == level[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = x[i];
          cnt_nxt[i]   = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    rise_nxt  = level_nxt & ~level;
    fall_nxt  = ~level_nxt & level;
    latch_nxt = rise_nxt | (latch & ~latch_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= {N_CH{RESET_LEVEL}};
      sync2      <= {N_CH{RESET_LEVEL}};
      level      <= {N_CH{RESET_LEVEL}};
      rise       <= '0;
      fall       <= '0;
      latch      <= '0;
      any_active <= RESET_LEVEL;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      level      <= level_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      latch      <= latch_nxt;
      any_active <= |level_nxt;
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_finalcarrera_multi.sv
// Bench for finalcarrera_multi: two instances (plain and channel-0 inverted) compared
// every cycle against a run-length model, plus directed latency/latch/reset checks.
module tb_finalcarrera_multi;
  localparam int N  = 2;
  localparam int FL = 8;
  localparam logic [N-1:0] INV1 = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] latch_clr = '0;

  logic [N-1:0] level0, rise0, fall0, latch0;
  logic any0;
  logic [N-1:0] level1, rise1, fall1, latch1;
  logic any1;

  always #5 clk = ~clk;

  finalcarrera_multi #(.N_CH(N), .FILTER_LEN(FL), .INVERT(2'b00), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .latch_clr(latch_clr),
    .level(level0), .rise(rise0), .fall(fall0), .latch(latch0), .any_active(any0));

  finalcarrera_multi #(.N_CH(N), .FILTER_LEN(FL), .INVERT(INV1), .RESET_LEVEL(1'b0)) dut_inv (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn), .latch_clr(latch_clr),
    .level(level1), .rise(rise1), .fall(fall1), .latch(latch1), .any_active(any1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
  endtask

  // Reference: a level flips once FL ticked samples in a row have disagreed with it.
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_lvl [2];
  logic [N-1:0] m_rise [2];
  logic [N-1:0] m_fall [2];
  logic [N-1:0] m_latch [2];
  logic         m_any [2];
  int           m_run [2][N];
  logic [N-1:0] m_x, m_old;

  function automatic logic [N-1:0] inv_of(input int d);
    return (d == 1) ? INV1 : '0;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_lvl[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_latch[d] = '0; m_any[d] = 1'b0;
      for (int c = 0; c < N; c++) m_run[d][c] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0;
        for (int d = 0; d < 2; d++) begin
          m_lvl[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_latch[d] = '0; m_any[d] = 1'b0;
          for (int c = 0; c < N; c++) m_run[d][c] = 0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          m_x   = m_s2 ^ inv_of(d);
          m_old = m_lvl[d];
          for (int c = 0; c < N; c++) begin
            if (m_x[c] == m_old[c]) m_run[d][c] = 0;
            else if (tick) begin
              m_run[d][c] = m_run[d][c] + 1;
              if (m_run[d][c] == FL) begin
                m_lvl[d][c] = m_x[c];
                m_run[d][c] = 0;
              end
            end
          end
          m_rise[d]  = m_lvl[d] & ~m_old;
          m_fall[d]  = m_old & ~m_lvl[d];
          m_latch[d] = m_rise[d] | (m_latch[d] & ~latch_clr);
          m_any[d]   = |m_lvl[d];
        end
        m_s2 = m_s1;
        m_s1 = btn;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_eq("lvl0", level0, m_lvl[0]);
      check_eq("rise0", rise0, m_rise[0]);
      check_eq("fall0", fall0, m_fall[0]);
      check_eq("latch0", latch0, m_latch[0]);
      check_eq("any0", any0, m_any[0]);
      check_eq("lvl1", level1, m_lvl[1]);
      check_eq("rise1", rise1, m_rise[1]);
      check_eq("fall1", fall1, m_fall[1]);
      check_eq("latch1", latch1, m_latch[1]);
      check_eq("any1", any1, m_any[1]);
    end
  end

  int lat;
  int mode;

  initial begin
    rst_n = 1'b0; tick = 1'b1; btn = '0; latch_clr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    repeat (20) @(negedge clk);
    check_eq("idle_lvl", level0, 0);
    check_eq("idle_latch", latch0, 0);
    check_eq("idle_any", any0, 0);
    check_eq("inv_idle_lvl", level1, 2'b01);
    check_eq("inv_idle_latch", latch1, 2'b01);

    // clean press and release
    btn[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (level0[0]) begin lat = k; break; end
    end
    check_eq("press_lat", lat, FL + 2);
    check_eq("press_rise", rise0[0], 1);
    @(negedge clk);
    check_eq("press_rise_drop", rise0[0], 0);
    check_eq("press_latch", latch0[0], 1);
    check_eq("press_any", any0, 1);
    btn[0] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fall0[0]) begin lat = k; break; end
    end
    check_eq("release_lat", lat, FL + 2);
    check_eq("release_lvl", level0[0], 0);

    // glitch: 7 high, 1 low, then high for good
    btn[1] = 1'b1;
    repeat (7) @(negedge clk);
    btn[1] = 1'b0;
    @(negedge clk);
    btn[1] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (level0[1]) begin lat = k; break; end
    end
    check_eq("glitch_lat", lat, FL + 2);

    // tick every 4th cycle
    btn[0] = 1'b1;
    for (int k = 0; k < 4 * FL + 16; k++) begin
      tick = (k % 4 == 3);
      @(negedge clk);
    end
    tick = 1'b1;
    check_eq("tick_pace_lvl", level0[0], 1);

    // latch clear, then set-wins priority
    check_eq("pre_clr_latch", latch0[0], 1);
    latch_clr[0] = 1'b1;
    @(negedge clk);
    latch_clr[0] = 1'b0;
    check_eq("clr_latch", latch0[0], 0);
    btn[0] = 1'b0;
    repeat (FL + 4) @(negedge clk);
    btn[0] = 1'b1;
    latch_clr[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rise0[0]) begin lat = k; break; end
    end
    check_eq("prio_seen", lat, FL + 2);
    check_eq("prio_latch", latch0[0], 1);
    @(negedge clk);
    check_eq("prio_held_clr", latch0[0], 0);
    latch_clr[0] = 1'b0;

    // async reset mid-count, then inverted channel recovers
    btn = 2'b00;
    repeat (FL + 4) @(negedge clk);
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_lvl", level0, 0);
    check_eq("arst_latch", latch0 | latch1, 0);
    check_eq("arst_any", any0 | any1, 0);
    btn = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 3 * FL; k++) begin
      @(negedge clk);
      if (rise1[0]) begin lat = k; break; end
    end
    check_eq("inv_rise_seen", lat != 0, 1);
    check_eq("inv_lvl", level1[0], 1);

    // randomized soak
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       tick = 1'b1;
        1:       tick = ($urandom_range(0, 3) == 0);
        default: tick = $urandom_range(0, 1);
      endcase
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
      latch_clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 3)) : '0;
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
